// File: rtl/boot_sequencer_pkg.sv
// boot_sequencer_pkg
//  Shared definitions for the Consolite power-up sequencer: FSM state
//  encodings (BOOT_*), error codes carried on error_code (BOOT_ERR_*), and the
//  STATE_* codes the status display shows for each boot outcome.
package boot_sequencer_pkg;

  typedef enum logic [2:0] {
    BOOT_WAIT_CALIB = 3'd0,
    BOOT_CLEAR_GO   = 3'd1,
    BOOT_CLEAR_WAIT = 3'd2,
    BOOT_SD_GO      = 3'd3,
    BOOT_SD_WAIT    = 3'd4,
    BOOT_RUN        = 3'd5,
    BOOT_FAIL       = 3'd6
  } boot_state_t;

  localparam logic [2:0] BOOT_ERR_NONE       = 3'd0;
  localparam logic [2:0] BOOT_ERR_CLEAR_TMO  = 3'd1;
  localparam logic [2:0] BOOT_ERR_SD_TMO     = 3'd2;
  localparam logic [2:0] BOOT_ERR_SD_FAIL    = 3'd3;
  localparam logic [2:0] BOOT_ERR_CALIB_LOST = 3'd4;

  // Display codes for the status logic; failures occupy the top of the range.
  localparam logic [3:0] STATE_BOOTING          = 4'h0;
  localparam logic [3:0] STATE_FAIL_CLEAR_TMO   = 4'hB;
  localparam logic [3:0] STATE_FAIL_SD_TMO      = 4'hC;
  localparam logic [3:0] STATE_FAIL_SD_ERROR    = 4'hD;
  localparam logic [3:0] STATE_FAIL_CALIB_LOST  = 4'hE;
  localparam logic [3:0] STATE_FAIL_UNKNOWN     = 4'hF;

  // Maps the sequencer's error level/code onto a display code.
  function automatic logic [3:0] boot_display_code(input logic boot_error,
                                                   input logic [2:0] code);
    logic [3:0] disp;
    disp = STATE_BOOTING;
    if (boot_error) begin
      case (code)
        BOOT_ERR_CLEAR_TMO:  disp = STATE_FAIL_CLEAR_TMO;
        BOOT_ERR_SD_TMO:     disp = STATE_FAIL_SD_TMO;
        BOOT_ERR_SD_FAIL:    disp = STATE_FAIL_SD_ERROR;
        BOOT_ERR_CALIB_LOST: disp = STATE_FAIL_CALIB_LOST;
        default:             disp = STATE_FAIL_UNKNOWN;
      endcase
    end
    return disp;
  endfunction

endpackage

// File: rtl/boot_sequencer_if.sv
// boot_sequencer_if
//  Groups the sequencer's engine handshakes and status levels.
//  master : the boot sequencer (drives start pulses and status levels)
//  slave  : the board side (calibration, clear engine, SD loader, display)
//
//  Handshake semantics: clear_start / sd_start are single-cycle pulses; the
//  matching engine answers with clear_done / sd_done (pulse or level) or
//  sd_error (pulse). An answer only counts while the sequencer is in the
//  matching wait phase, so a level left over from an earlier run is ignored
//  until the engine has been started again.
interface boot_sequencer_if;
  logic       mem_calib_done;
  logic       clear_start;
  logic       clear_done;
  logic       sd_start;
  logic       sd_done;
  logic       sd_error;
  logic       clear_screen_done;
  logic       sdcard_read_done;
  logic       cpu_run;
  logic       boot_error;
  logic [2:0] error_code;

  modport master (
    input  mem_calib_done, clear_done, sd_done, sd_error,
    output clear_start, sd_start, clear_screen_done, sdcard_read_done,
           cpu_run, boot_error, error_code
  );

  modport slave (
    output mem_calib_done, clear_done, sd_done, sd_error,
    input  clear_start, sd_start, clear_screen_done, sdcard_read_done,
           cpu_run, boot_error, error_code
  );
endinterface

// File: rtl/boot_sequencer.sv
// boot_sequencer
//  Power-up sequencer: wait for LPDDR calibration, pulse the video-memory
//  clear engine, pulse the SD image loader (with bounded retries on sd_error),
//  then release the CPU. Each wait phase has a timeout; any failure parks the
//  FSM in a sticky failure state with an error code.
// Ports
//  clk       : system clock
//  rst       : asynchronous active-high reset
//  bus       : boot_sequencer_if.master (calib/done/error in, start/status out)
//  dbg_state : current FSM state for observation
// Parameters
//  TIMEOUT_CYCLES : cycles allowed in each wait phase
//  TIMEOUT_W      : timeout counter width, must hold TIMEOUT_CYCLES
//  SD_RETRIES     : extra sd_start attempts after sd_error
module boot_sequencer
  import boot_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int TIMEOUT_W      = 26,
  parameter int SD_RETRIES     = 2
) (
  input  logic                clk,
  input  logic                rst,
  boot_sequencer_if.master    bus,
  output boot_state_t         dbg_state
);

  localparam int RETRY_W = (SD_RETRIES < 1) ? 1 : $clog2(SD_RETRIES + 1);

  boot_state_t          state;
  boot_state_t          state_next;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [RETRY_W-1:0]   retries_used;
  logic                 clear_flag;
  logic                 sd_flag;
  logic [2:0]           err_q;

  logic                 set_clear;
  logic                 set_sd;
  logic                 retry_inc;
  logic [2:0]           fail_code;
  logic                 timeout_hit;
  logic                 calib_lost;
  logic                 in_wait;

  assign in_wait     = (state == BOOT_CLEAR_WAIT) || (state == BOOT_SD_WAIT);
  assign timeout_hit = (tmo_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
  // Calibration is only required once it has been seen; FAIL is already terminal.
  assign calib_lost  = !bus.mem_calib_done &&
                       (state != BOOT_WAIT_CALIB) && (state != BOOT_FAIL);

  always_comb begin
    state_next = state;
    set_clear  = 1'b0;
    set_sd     = 1'b0;
    retry_inc  = 1'b0;
    fail_code  = BOOT_ERR_NONE;

    case (state)
      BOOT_WAIT_CALIB: if (bus.mem_calib_done) state_next = BOOT_CLEAR_GO;
      BOOT_CLEAR_GO:   state_next = BOOT_CLEAR_WAIT;
      BOOT_CLEAR_WAIT: begin
        // A done on the last allowed cycle still wins over the timeout.
        if (bus.clear_done) begin
          state_next = BOOT_SD_GO;
          set_clear  = 1'b1;
        end else if (timeout_hit) begin
          state_next = BOOT_FAIL;
          fail_code  = BOOT_ERR_CLEAR_TMO;
        end
      end
      BOOT_SD_GO:      state_next = BOOT_SD_WAIT;
      BOOT_SD_WAIT: begin
        // sd_error outranks a simultaneous sd_done.
        if (bus.sd_error) begin
          if (retries_used < RETRY_W'(SD_RETRIES)) begin
            state_next = BOOT_SD_GO;
            retry_inc  = 1'b1;
          end else begin
            state_next = BOOT_FAIL;
            fail_code  = BOOT_ERR_SD_FAIL;
          end
        end else if (bus.sd_done) begin
          state_next = BOOT_RUN;
          set_sd     = 1'b1;
        end else if (timeout_hit) begin
          state_next = BOOT_FAIL;
          fail_code  = BOOT_ERR_SD_TMO;
        end
      end
      BOOT_RUN:        state_next = BOOT_RUN;
      BOOT_FAIL:       state_next = BOOT_FAIL;
      default:         state_next = BOOT_WAIT_CALIB;
    endcase

    // Losing calibration overrides whatever the phase logic decided.
    if (calib_lost) begin
      state_next = BOOT_FAIL;
      fail_code  = BOOT_ERR_CALIB_LOST;
      set_clear  = 1'b0;
      set_sd     = 1'b0;
      retry_inc  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT_WAIT_CALIB;
      tmo_cnt      <= '0;
      retries_used <= '0;
      clear_flag   <= 1'b0;
      sd_flag      <= 1'b0;
      err_q        <= BOOT_ERR_NONE;
    end else begin
      state <= state_next;
      // Every wait phase is entered from its GO state, so clearing there
      // restarts the count on each entry, retries included.
      if ((state == BOOT_CLEAR_GO) || (state == BOOT_SD_GO)) begin
        tmo_cnt <= '0;
      end else if (in_wait) begin
        tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
      end
      if (retry_inc) retries_used <= retries_used + RETRY_W'(1);
      if (set_clear) clear_flag <= 1'b1;
      if (set_sd)    sd_flag    <= 1'b1;
      // Code is captured only on the transition into FAIL.
      if ((state_next == BOOT_FAIL) && (state != BOOT_FAIL)) err_q <= fail_code;
    end
  end

  assign bus.clear_start       = (state == BOOT_CLEAR_GO);
  assign bus.sd_start          = (state == BOOT_SD_GO);
  assign bus.cpu_run           = (state == BOOT_RUN);
  assign bus.boot_error        = (state == BOOT_FAIL);
  assign bus.clear_screen_done = clear_flag;
  assign bus.sdcard_read_done  = sd_flag;
  assign bus.error_code        = err_q;
  assign dbg_state             = state;

endmodule

// File: tb/tb_boot_sequencer.sv
// tb_boot_sequencer
//  Plans per-scenario input waveforms (calibration level, engine answers) as
//  cycle-indexed arrays, derives the expected event timeline from the boot
//  rules, and compares it against events observed on the DUT outputs.
module tb_boot_sequencer;
  import boot_sequencer_pkg::*;

  localparam int T = 100;
  localparam int R = 2;
  localparam int N = 640;

  localparam int EV_CLR = 1;
  localparam int EV_SD  = 2;
  localparam int EV_RUN = 3;
  localparam int EV_ERR = 4;

  localparam int K_DONE = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  logic        clk;
  logic        rst;
  boot_state_t dbg_state;
  boot_sequencer_if bif();

  boot_sequencer #(
    .TIMEOUT_CYCLES(T),
    .TIMEOUT_W(7),
    .SD_RETRIES(R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif.master),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle index ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- planned inputs ----------------
  bit p_calib[N];
  bit p_cd[N];
  bit p_sdd[N];
  bit p_sde[N];

  initial begin
    bif.mem_calib_done = 1'b0;
    bif.clear_done     = 1'b0;
    bif.sd_done        = 1'b0;
    bif.sd_error       = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cyc < N) begin
        bif.mem_calib_done = p_calib[cyc];
        bif.clear_done     = p_cd[cyc];
        bif.sd_done        = p_sdd[cyc];
        bif.sd_error       = p_sde[cyc];
      end else begin
        bif.mem_calib_done = 1'b0;
        bif.clear_done     = 1'b0;
        bif.sd_done        = 1'b0;
        bif.sd_error       = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit active = 0;
  bit exp_csd, exp_srd, exp_run, exp_err;
  int exp_code;

  function automatic logic [31:0] ev(input int kind, input int code, input int at);
    return {4'(kind), 4'(code), 24'(at)};
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic observe(input logic [31:0] got);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d code=%0d cycle=%0d, none expected",
               got[31:28], got[27:24], got[23:0]);
    end else begin
      e = exp_q.pop_front();
      if (e != got) begin
        errors++;
        $display("FAIL event: got kind=%0d code=%0d cycle=%0d expected kind=%0d code=%0d cycle=%0d",
                 got[31:28], got[27:24], got[23:0], e[31:28], e[27:24], e[23:0]);
      end
    end
  endtask

  bit prev_run, prev_err;
  always @(negedge clk) begin
    if (rst) begin
      prev_run = 1'b0;
      prev_err = 1'b0;
    end else if (active && cyc < N) begin
      if (bif.clear_start) observe(ev(EV_CLR, 0, cyc));
      if (bif.sd_start)    observe(ev(EV_SD, 0, cyc));
      if (bif.cpu_run && !prev_run)    observe(ev(EV_RUN, 0, cyc));
      if (bif.boot_error && !prev_err) observe(ev(EV_ERR, int'(bif.error_code), cyc));
      prev_run = bif.cpu_run;
      prev_err = bif.boot_error;
    end
  end

  // ---------------- reference model ----------------
  task automatic push(input int kind, input int code, input int at);
    if (at < N) exp_q.push_back(ev(kind, code, at));
  endtask

  task automatic m_fail(input int code, input int at);
    if (at < N) begin
      exp_err  = 1;
      exp_code = code;
      exp_run  = 0;
      push(EV_ERR, code, at);
    end
  endtask

  // Walks the planned inputs phase by phase: each start pulse is the cycle
  // after the triggering observation, each wait lasts at most T cycles.
  task automatic model_run();
    int t, g, w, k, r, retries;
    bit hit;
    exp_csd = 0; exp_srd = 0; exp_run = 0; exp_err = 0; exp_code = 0;
    t = 0;
    while (t < N && !p_calib[t]) t++;
    g = t + 1;
    if (g >= N) return;
    push(EV_CLR, 0, g);
    if (!p_calib[g]) begin m_fail(4, g + 1); return; end
    w = g + 1; hit = 0; k = w;
    while (k < w + T && k < N && !hit) begin
      if (!p_calib[k]) begin m_fail(4, k + 1); return; end
      if (p_cd[k]) hit = 1; else k++;
    end
    if (!hit) begin m_fail(1, w + T); return; end
    exp_csd = (k + 1 < N);
    g = k + 1; retries = 0; r = N;
    forever begin
      if (g >= N) return;
      push(EV_SD, 0, g);
      if (!p_calib[g]) begin m_fail(4, g + 1); return; end
      w = g + 1; hit = 0; k = w;
      while (k < w + T && k < N && !hit) begin
        if (!p_calib[k]) begin m_fail(4, k + 1); return; end
        if (p_sde[k] || p_sdd[k]) hit = 1; else k++;
      end
      if (!hit) begin m_fail(2, w + T); return; end
      if (p_sde[k]) begin
        if (retries < R) begin retries++; g = k + 1; end
        else begin m_fail(3, k + 1); return; end
      end else begin
        exp_srd = (k + 1 < N);
        r = k + 1;
        break;
      end
    end
    if (r >= N) return;
    push(EV_RUN, 0, r);
    exp_run = 1;
    for (int j = r; j < N; j++) begin
      if (!p_calib[j]) begin m_fail(4, j + 1); return; end
    end
  endtask

  // ---------------- stimulus planning ----------------
  // Engine answers are placed relative to the start pulse they answer,
  // assuming the intended boot path; delay d means d cycles after the pulse.
  task automatic gen(input int calib_at, input int drop_at, input int clear_d, input bit hold_cd,
                     input int k0, input int d0, input int k1, input int d1,
                     input int k2, input int d2);
    int g, pos, kind, d;
    for (int t = 0; t < N; t++) begin
      p_calib[t] = (t >= calib_at) && (drop_at < 0 || t < drop_at);
      p_cd[t]    = hold_cd;
      p_sdd[t]   = 1'b0;
      p_sde[t]   = 1'b0;
    end
    g = calib_at + 1;
    if (clear_d > 0 && g + clear_d < N) p_cd[g + clear_d] = 1'b1;
    if (clear_d < 1 || clear_d > T) return;
    g = g + clear_d + 1;
    for (int i = 0; i < 3; i++) begin
      kind = (i == 0) ? k0 : (i == 1) ? k1 : k2;
      d    = (i == 0) ? d0 : (i == 1) ? d1 : d2;
      if (kind == K_NONE) return;
      pos = g + d;
      if (pos < N) begin
        if (kind == K_DONE || kind == K_BOTH) p_sdd[pos] = 1'b1;
        if (kind == K_ERR  || kind == K_BOTH) p_sde[pos] = 1'b1;
      end
      if (kind == K_DONE || d > T) return;
      g = pos + 1;
    end
  endtask

  task automatic run_scn(input int calib_at, input int drop_at, input int clear_d, input bit hold_cd,
                         input int k0, input int d0, input int k1, input int d1,
                         input int k2, input int d2);
    rst = 1'b1;
    exp_q.delete();
    gen(calib_at, drop_at, clear_d, hold_cd, k0, d0, k1, d1, k2, d2);
    model_run();
    @(posedge clk);
    #1 rst = 1'b0;
    active = 1'b1;
    repeat (N - 1) @(posedge clk);
    @(negedge clk);
    #1;
    chk("missing_events", exp_q.size(), 0);
    chk("clear_screen_done", int'(bif.clear_screen_done), int'(exp_csd));
    chk("sdcard_read_done", int'(bif.sdcard_read_done), int'(exp_srd));
    chk("cpu_run", int'(bif.cpu_run), int'(exp_run));
    chk("boot_error", int'(bif.boot_error), int'(exp_err));
    chk("error_code", int'(bif.error_code), exp_code);
    active = 1'b0;
    rst = 1'b1;
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_clear_start"}, int'(bif.clear_start), 0);
    chk({tag, "_sd_start"}, int'(bif.sd_start), 0);
    chk({tag, "_clear_screen_done"}, int'(bif.clear_screen_done), 0);
    chk({tag, "_sdcard_read_done"}, int'(bif.sdcard_read_done), 0);
    chk({tag, "_cpu_run"}, int'(bif.cpu_run), 0);
    chk({tag, "_boot_error"}, int'(bif.boot_error), 0);
    chk({tag, "_error_code"}, int'(bif.error_code), 0);
  endtask

  // Reset asserted between edges, once deep in SD_WAIT and once while
  // clear_start is high; outputs must drop without waiting for a clock.
  task automatic reset_tests();
    active = 1'b0;
    rst = 1'b1;
    // calib@5 -> clear_start cycle 6, clear_done cycle 16, sd_start cycle 17.
    gen(5, -1, 10, 1'b0, K_DONE, 50, K_NONE, 0, K_NONE, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (27) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_clear_screen_done", int'(bif.clear_screen_done), 1);
    chk("pre_reset_cpu_run", int'(bif.cpu_run), 0);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_in_sd_wait");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("pulse_before_reset", int'(bif.clear_start), 1);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_in_pulse");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cd, r, kk[3], dd[3], drop;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");

    run_scn(10, -1, 50, 1'b0, K_DONE, 80, K_NONE, 0, K_NONE, 0);       // happy path
    run_scn(10, -1, 0, 1'b0, K_NONE, 0, K_NONE, 0, K_NONE, 0);         // clear timeout
    run_scn(3, -1, 20, 1'b0, K_ERR, 20, K_ERR, 30, K_ERR, 40);         // retries spent
    run_scn(3, -1, 20, 1'b0, K_ERR, 5, K_ERR, 6, K_DONE, 7);           // success on last retry
    run_scn(3, -1, 20, 1'b0, K_BOTH, 10, K_ERR, 5, K_BOTH, 9);         // error wins over done
    run_scn(2, -1, T, 1'b0, K_DONE, T, K_NONE, 0, K_NONE, 0);          // done on final cycles
    run_scn(2, -1, T + 1, 1'b0, K_DONE, 5, K_NONE, 0, K_NONE, 0);      // clear done one late
    run_scn(2, -1, 30, 1'b0, K_NONE, 0, K_NONE, 0, K_NONE, 0);         // sd timeout
    run_scn(4, 300, 20, 1'b0, K_DONE, 30, K_NONE, 0, K_NONE, 0);       // calib lost in RUN
    run_scn(4, 30, 50, 1'b0, K_DONE, 10, K_NONE, 0, K_NONE, 0);        // calib lost in CLEAR_WAIT

    reset_tests();
    run_scn(0, -1, 1, 1'b1, K_DONE, 40, K_NONE, 0, K_NONE, 0);         // stale clear_done level

    for (int s = 0; s < 16; s++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      cd = 0;
      else if (r == 1) cd = T;
      else if (r == 2) cd = T + 1;
      else             cd = $urandom_range(1, T - 1);
      for (int i = 0; i < 3; i++) begin
        r = $urandom_range(0, 9);
        kk[i] = (r < 4) ? K_DONE : (r < 7) ? K_ERR : (r < 9) ? K_BOTH : K_NONE;
        r = $urandom_range(0, 9);
        dd[i] = (r == 0) ? T : (r == 1) ? T + 1 : $urandom_range(1, T - 1);
      end
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 550) : -1;
      run_scn($urandom_range(0, 15), drop, cd, 1'b0, kk[0], dd[0], kk[1], dd[1], kk[2], dd[2]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
